// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path types and constants
package cpu_pkg;

    localparam int              XLEN        = 32;
    localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
    localparam int              INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o,
    output logic         full_o
);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot the push needs, so full-with-pop still accepts.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, credit-limited imem requests, redirect/discard handling
module fetch_unit #(
    parameter int                XLEN       = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC   = cpu_pkg::RESET_PC,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                   req_en_q;
    logic [XLEN-1:0]        fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]        resp_pc_q, resp_pc_d;
    logic [CW-1:0]          outstanding_q, outstanding_d;
    logic [CW-1:0]          discard_q, discard_d;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            credit_used;
    logic                   fifo_empty, fifo_full;
    logic                   acc, rsp, drop, push, pop;
    logic [XLEN-1:0]        target_pc;
    cpu_pkg::fetch_entry_t  push_entry, head_entry;

    // Held low through reset so the request cannot assert before the first post-reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_en_q <= 1'b0;
        else        req_en_q <= 1'b1;
    end

    assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = req_en_q & (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr      = fetch_pc_q;

    assign acc       = imem_req_valid & imem_req_ready;
    assign rsp       = imem_rsp_valid;
    assign drop      = rsp & (discard_q != '0);
    assign push      = rsp & ~drop & ~redirect;
    assign pop       = instr_valid & instr_ready & ~redirect;
    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(acc) - CW'(rsp);
        if (acc) fetch_pc_d = fetch_pc_q + XLEN'(cpu_pkg::INSTR_BYTES);
        if (drop)     discard_d = discard_q - CW'(1);
        else if (rsp) resp_pc_d = resp_pc_q + XLEN'(cpu_pkg::INSTR_BYTES);
        // Everything still in flight after this edge belongs to the old stream.
        if (redirect) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign push_entry = '{pc: resp_pc_q, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign instr_valid = ~fifo_empty;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

    a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding_q != '0));
    a_fifo_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CW'(FIFO_DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (fifo_full && push) |-> pop);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and random checks of fetch_unit against a stream-level model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

    int          total = 0;
    int          bad = 0;
    req_t        pending[$];
    ent_t        buf_m[$];
    logic [31:0] cons_q[$];
    logic [31:0] next_fetch, next_consume;
    int          epoch = 0;
    int          consumed, acc_seen;
    bit          rand_mode = 0;
    int          rsp_pct = 100;
    bit          p_ready = 1, p_iready = 1, p_redirect = 0;
    logic [31:0] p_target = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        buf_m.delete();
        next_fetch   = 32'h0;
        next_consume = 32'h0;
        epoch++;
    endtask

    // One clock: compare outputs, drive inputs for the coming edge, advance the model.
    task automatic step();
        req_t r;
        ent_t e;
        bit   exp_rv;
        @(negedge clk);
        exp_rv = (pending.size() + buf_m.size()) < 2;
        check("instr_valid", instr_valid, buf_m.size() > 0);
        if (buf_m.size() > 0) begin
            check("instr_pc", instr_pc, buf_m[0].pc);
            check("instr", instr, buf_m[0].word);
        end
        check("req_valid", imem_req_valid, exp_rv);
        if (rand_mode) begin
            p_ready    = $urandom_range(0, 99) < 70;
            p_iready   = $urandom_range(0, 99) < 60;
            p_redirect = $urandom_range(0, 99) < 6;
            case ($urandom_range(0, 3))
                0:       p_target = $urandom;
                1:       p_target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: p_target = $urandom_range(0, 1023);
            endcase
        end
        imem_req_ready = p_ready;
        instr_ready    = p_iready;
        redirect       = p_redirect;
        redirect_pc    = p_target;
        if (pending.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if (buf_m.size() > 0 && instr_ready && !redirect) begin
            check("consume_pc", instr_pc, next_consume);
            cons_q.push_back(instr_pc);
            next_consume += 32'd4;
            consumed++;
            void'(buf_m.pop_front());
        end
        if (imem_rsp_valid) begin
            r = pending.pop_front();
            if (!redirect && r.epoch == epoch) begin
                e.pc   = r.addr;
                e.word = mem_word(r.addr);
                buf_m.push_back(e);
            end
        end
        if (exp_rv && imem_req_ready) begin
            check("imem_addr", imem_addr, next_fetch);
            r.addr  = next_fetch;
            r.epoch = epoch;
            pending.push_back(r);
            next_fetch += 32'd4;
            acc_seen++;
        end
        if (redirect) begin
            buf_m.delete();
            epoch++;
            next_fetch   = {redirect_pc[31:2], 2'b00};
            next_consume = next_fetch;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        p_redirect     = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("rst_req_valid", imem_req_valid, 1'b0);
            check("rst_instr_valid", instr_valid, 1'b0);
        end
        rst_n = 1'b1;

        // Streaming fetch with single-cycle memory and an always-ready decode
        p_ready = 1; p_iready = 1; rsp_pct = 100;
        consumed = 0; cons_q.delete();
        repeat (12) step();
        check("t1_progress", consumed >= 3, 1'b1);
        check("t1_pc0", cons_q.size() > 2 ? cons_q[0] : 32'hDEAD_BEEF, 32'h0);
        check("t1_pc2", cons_q.size() > 2 ? cons_q[2] : 32'hDEAD_BEEF, 32'h8);

        // Decode stalled: credit caps fetch at two
        hard_reset();
        p_iready = 0; acc_seen = 0;
        repeat (10) step();
        settle();
        check("t2_acc_count", acc_seen, 2);
        check("t2_req_low", imem_req_valid, 1'b0);
        check("t2_head_pc", instr_pc, 32'h0);
        p_iready = 1; consumed = 0; cons_q.delete();
        repeat (10) step();
        check("t2_resume", consumed >= 3, 1'b1);
        check("t2_third_pc", cons_q.size() > 2 ? cons_q[2] : 32'hDEAD_BEEF, 32'h8);

        // Redirect with two stale requests outstanding
        hard_reset();
        rsp_pct = 0;
        repeat (3) step();
        p_redirect = 1; p_target = 32'h100;
        step();
        p_redirect = 0;
        settle();
        check("t3_flushed", instr_valid, 1'b0);
        check("t3_credit_held", imem_req_valid, 1'b0);
        rsp_pct = 100; consumed = 0; cons_q.delete();
        repeat (10) step();
        check("t3_first_pc", cons_q.size() > 0 ? cons_q[0] : 32'hDEAD_BEEF, 32'h100);

        // Redirect coinciding with an accepted request and an arriving response
        hard_reset();
        step();
        p_redirect = 1; p_target = 32'h200;
        step();
        p_redirect = 0; consumed = 0; cons_q.delete();
        repeat (10) step();
        check("t4_first_pc", cons_q.size() > 0 ? cons_q[0] : 32'hDEAD_BEEF, 32'h200);

        // Misaligned target and PC wrap
        p_redirect = 1; p_target = 32'h103;
        step();
        p_redirect = 0;
        settle();
        check("t5_align_addr", imem_addr, 32'h100);
        repeat (6) step();
        p_redirect = 1; p_target = 32'hFFFF_FFFC;
        step();
        p_redirect = 0; cons_q.delete();
        settle();
        check("t5_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        repeat (10) step();
        check("t5_wrap_pc0", cons_q.size() > 1 ? cons_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("t5_wrap_pc1", cons_q.size() > 1 ? cons_q[1] : 32'hDEAD_BEEF, 32'h0);

        // Asynchronous reset with a full buffer
        hard_reset();
        p_iready = 0;
        repeat (8) step();
        settle();
        check("t6_full_valid", instr_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_instr_valid", instr_valid, 1'b0);
        check("t6_async_req_valid", imem_req_valid, 1'b0);
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        p_iready = 1; cons_q.delete();
        repeat (8) step();
        check("t6_restart_pc", cons_q.size() > 0 ? cons_q[0] : 32'hDEAD_BEEF, 32'h0);

        // Random traffic
        rand_mode = 1; rsp_pct = 60; consumed = 0;
        repeat (3000) step();
        rand_mode = 0; p_redirect = 0; p_iready = 1; p_ready = 1; rsp_pct = 100;
        repeat (10) step();
        check("rand_progress", consumed > 100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
